// File: rtl/nios_cpu_mult_pipe_if.sv
// Issue/writeback handshake bundle for the pipelined Nios multiplier.
// master = issuing execute stage, slave = multiplier.
interface nios_cpu_mult_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/nios_cpu_mult_pipe.sv
// Pipelined MUL/MULXUU/MULXSU/MULXSS unit: half-word partial products in stage 1,
// summation in stage 2 (pass-through to LATENCY-1), word select in stage LATENCY.
module nios_cpu_mult_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  nios_cpu_mult_pipe_if.slave  bus
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic                en, acc;
  logic [LATENCY:1]    vld_pipe;
  logic [1:0]          op_pipe  [1:LATENCY-1];
  logic [TAG_W-1:0]    tag_pipe [1:LATENCY];
  logic [WIDTH:0]      a_x, b_x;
  logic [WIDTH+1:0]    a_lo, a_hi, b_lo, b_hi;
  logic [WIDTH+1:0]    pp_ll, pp_lh, pp_hl, pp_hh;
  logic [WIDTH+1:0]    pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [PW-1:0]       ll_e, lh_e, hl_e, hh_e, sum_c, p_last;
  logic [WIDTH-1:0]    res_q;

  assign en  = ~vld_pipe[LATENCY] | bus.out_ready;
  assign acc = bus.in_valid & en;

  // Halves are fully sign-extended to WIDTH+2 bits, so a plain modular multiply
  // gives the exact signed partial product (every true value fits in WIDTH+2).
  always_comb begin
    a_x   = {bus.in_op[1] & bus.in_src1[WIDTH-1], bus.in_src1};
    b_x   = {(bus.in_op == 2'b11) & bus.in_src2[WIDTH-1], bus.in_src2};
    a_lo  = {{(H+2){1'b0}}, a_x[H-1:0]};
    b_lo  = {{(H+2){1'b0}}, b_x[H-1:0]};
    a_hi  = {{(H+1){a_x[WIDTH]}}, a_x[WIDTH:H]};
    b_hi  = {{(H+1){b_x[WIDTH]}}, b_x[WIDTH:H]};
    pp_ll = a_lo * b_lo;
    pp_lh = a_lo * b_hi;
    pp_hl = a_hi * b_lo;
    pp_hh = a_hi * b_hi;
  end

  // Only the low 2*WIDTH product bits are ever selected, so summing mod 2^PW is exact.
  always_comb begin
    ll_e  = {{(PW-WIDTH-2){pp_ll_q[WIDTH+1]}}, pp_ll_q};
    lh_e  = {{(PW-WIDTH-2){pp_lh_q[WIDTH+1]}}, pp_lh_q};
    hl_e  = {{(PW-WIDTH-2){pp_hl_q[WIDTH+1]}}, pp_hl_q};
    hh_e  = {{(PW-WIDTH-2){pp_hh_q[WIDTH+1]}}, pp_hh_q};
    sum_c = (hh_e << WIDTH) + ((lh_e + hl_e) << H) + ll_e;
  end

  generate
    if (LATENCY == 2) begin : g_nosum
      assign p_last = sum_c;
    end else begin : g_sum
      logic [PW-1:0] p_pipe [2:LATENCY-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 2; i < LATENCY; i++) p_pipe[i] <= '0;
        end else if (en) begin
          p_pipe[2] <= sum_c;
          for (int i = 3; i < LATENCY; i++) p_pipe[i] <= p_pipe[i-1];
        end
      end
      assign p_last = p_pipe[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      pp_ll_q  <= '0;
      pp_lh_q  <= '0;
      pp_hl_q  <= '0;
      pp_hh_q  <= '0;
      res_q    <= '0;
      for (int i = 1; i < LATENCY; i++)  op_pipe[i]  <= '0;
      for (int i = 1; i <= LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      // flush kills validity even while stalled; data may keep stale values
      if (bus.flush)  vld_pipe <= '0;
      else if (en)    vld_pipe <= {vld_pipe[LATENCY-1:1], acc};
      if (en) begin
        pp_ll_q     <= pp_ll;
        pp_lh_q     <= pp_lh;
        pp_hl_q     <= pp_hl;
        pp_hh_q     <= pp_hh;
        op_pipe[1]  <= bus.in_op;
        tag_pipe[1] <= bus.in_tag;
        for (int i = 2; i < LATENCY; i++)  op_pipe[i]  <= op_pipe[i-1];
        for (int i = 2; i <= LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        res_q <= (op_pipe[LATENCY-1] == 2'b00) ? p_last[WIDTH-1:0] : p_last[PW-1:WIDTH];
      end
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = vld_pipe[LATENCY];
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_pipe[LATENCY];
  assign bus.busy       = |vld_pipe;
endmodule

// File: tb/tb_nios_cpu_mult_pipe.sv
// Bench for nios_cpu_mult_pipe: directed table + corner sequences on a 32/3 instance,
// random streams with backpressure on 16/2 and 32/6 instances, all via scoreboards.
module tb_nios_cpu_mult_pipe;
  localparam int NOPS = 300;

  typedef struct { logic [63:0] res; logic [4:0] tag; } exp_t;
  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] tag; logic [31:0] exp; } vec_t;

  logic clk;
  logic reset;
  logic rreset;
  int   n_pass, n_total, n_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rreset = 1'b1;
    #17 rreset = 1'b0;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  // Direct mathematical definition of the product, independent of any decomposition.
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    ea = $signed({66'd0, a & m});
    eb = $signed({66'd0, b & m});
    if (op[1] && a[w-1])         ea = ea - (130'sd1 <<< w);
    if (op == 2'b11 && b[w-1])   eb = eb - (130'sd1 <<< w);
    p = ea * eb;
    ref_mul = (op == 2'b00) ? (p[63:0] & m) : (64'(p >>> w) & m);
  endfunction

  // ---------------- main 32-bit, LATENCY=3 instance ----------------
  nios_cpu_mult_pipe_if #(.WIDTH(32), .TAG_W(5)) mif();
  nios_cpu_mult_pipe #(.WIDTH(32), .LATENCY(3), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .bus(mif)
  );

  exp_t        sbq[$];
  logic [63:0] cur_exp;
  int          n_out;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sbq.delete();
    end else begin
      if (mif.out_valid && mif.out_ready) begin
        n_out++;
        if (sbq.size() == 0) fail_now("unexpected_output");
        else begin
          e = sbq.pop_front();
          check("result", 64'(mif.out_result), e.res);
          check("tag", 64'(mif.out_tag), 64'(e.tag));
        end
      end
      if (mif.flush) sbq.delete();
      else if (mif.in_valid && mif.in_ready) sbq.push_back('{cur_exp, mif.in_tag});
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    logic ok;
    mif.in_op = op; mif.in_src1 = a; mif.in_src2 = b; mif.in_tag = tag;
    cur_exp = 64'(exp);
    mif.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = mif.in_ready;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[10];
    int   n0;
    n_pass = 0; n_total = 0; n_done = 0; n_out = 0;
    tbl[0] = '{2'b00, 32'h00010003, 32'h00020005, 5'd7,  32'h000B000F};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 5'd1,  32'h00000001};
    tbl[2] = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd2,  32'hFFFFFFFF};
    tbl[3] = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF};
    tbl[4] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFE};
    tbl[5] = '{2'b11, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000};
    tbl[6] = '{2'b10, 32'h00000002, 32'hFFFFFFFF, 5'd6,  32'h00000001};
    tbl[7] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE};
    tbl[8] = '{2'b11, 32'h7FFFFFFF, 32'h80000000, 5'd9,  32'hC0000000};
    tbl[9] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000000};

    reset = 1'b1;
    mif.flush = 1'b0; mif.in_valid = 1'b0; mif.in_op = 2'b00;
    mif.in_src1 = '0; mif.in_src2 = '0; mif.in_tag = '0; mif.out_ready = 1'b1;
    cur_exp = '0;
    #12;
    check("rst_out_valid", 64'(mif.out_valid), 64'd0);
    check("rst_out_result", 64'(mif.out_result), 64'd0);
    check("rst_out_tag", 64'(mif.out_tag), 64'd0);
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_in_ready", 64'(mif.in_ready), 64'd1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // latency: accepted at edge N, valid only after edge N+2
    issue(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].tag, tbl[0].exp);
    check("lat_edge0_valid", 64'(mif.out_valid), 64'd0);
    check("lat_edge0_busy", 64'(mif.busy), 64'd1);
    @(posedge clk); #1;
    check("lat_edge1_valid", 64'(mif.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 64'(mif.out_valid), 64'd1);
    drain();

    // table, back-to-back
    for (int i = 0; i < 10; i++) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp);
    drain();

    // backpressure: 4 ops while output stalled for 5 cycles
    n0 = n_out;
    mif.out_ready = 1'b0;
    fork
      for (int t = 1; t <= 4; t++) issue(2'b00, 32'(t), 32'h10, 5'(t), 32'(t * 16));
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_in_ready", 64'(mif.in_ready), 64'd0);
        check("bp_out_valid", 64'(mif.out_valid), 64'd1);
        check("bp_out_tag_held", 64'(mif.out_tag), 64'd1);
        mif.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(n_out - n0), 64'd4);

    // flush with 3 in flight, oldest stalled on the output
    issue(2'b00, 32'd3, 32'd3, 5'd10, 32'd9);
    issue(2'b00, 32'd4, 32'd4, 5'd11, 32'd16);
    issue(2'b00, 32'd5, 32'd5, 5'd12, 32'd25);
    mif.out_ready = 1'b0;
    mif.flush = 1'b1;
    check("fl_pre_valid", 64'(mif.out_valid), 64'd1);
    @(posedge clk); #1;
    mif.flush = 1'b0;
    check("fl_out_valid", 64'(mif.out_valid), 64'd0);
    check("fl_busy", 64'(mif.busy), 64'd0);
    mif.out_ready = 1'b1;
    n0 = n_out;
    issue(2'b00, 32'd123, 32'd456, 5'd13, 32'd56088);
    drain();
    check("fl_after_count", 64'(n_out - n0), 64'd1);

    // asynchronous reset between edges
    mif.out_ready = 1'b0;
    issue(2'b00, 32'd5, 32'd9, 5'd3, 32'd45);
    @(posedge clk); @(posedge clk); #1;
    check("ar_pre_valid", 64'(mif.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 64'(mif.out_valid), 64'd0);
    check("ar_busy", 64'(mif.busy), 64'd0);
    check("ar_out_result", 64'(mif.out_result), 64'd0);
    check("ar_out_tag", 64'(mif.out_tag), 64'd0);
    @(posedge clk); #3 reset = 1'b0;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    n0 = n_out;
    issue(2'b00, 32'd7, 32'd6, 5'd21, 32'd42);
    drain();
    check("ar_after_count", 64'(n_out - n0), 64'd1);

    for (int i = 0; i < 30000 && n_done < 2; i++) @(posedge clk);
    if (n_done < 2) fail_now("random_timeout");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // ---------------- random instances: 16/2 and 32/6 ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 16 : 32;
    localparam int L = (gi == 0) ? 2 : 6;

    nios_cpu_mult_pipe_if #(.WIDTH(W), .TAG_W(5)) rif();
    nios_cpu_mult_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(5)) rdut (
      .clk(clk), .reset(rreset), .bus(rif)
    );

    exp_t q[$];
    int   n_acc, n_got;

    always @(negedge clk) begin
      exp_t e;
      if (!rreset) begin
        if (rif.out_valid && rif.out_ready) begin
          n_got++;
          if (q.size() == 0) fail_now("rnd_unexpected_output");
          else begin
            e = q.pop_front();
            check("rnd_result", 64'(rif.out_result), e.res);
            check("rnd_tag", 64'(rif.out_tag), 64'(e.tag));
          end
        end
        if (rif.in_valid && rif.in_ready) begin
          q.push_back('{ref_mul(W, rif.in_op, 64'(rif.in_src1), 64'(rif.in_src2)), rif.in_tag});
          n_acc++;
        end
      end
    end

    initial begin
      int last, cyc;
      logic [63:0] a, b;
      n_acc = 0; n_got = 0; last = 0; cyc = 0;
      rif.flush = 1'b0; rif.in_valid = 1'b0; rif.in_op = 2'b00;
      rif.in_src1 = '0; rif.in_src2 = '0; rif.in_tag = '0; rif.out_ready = 1'b1;
      wait (!rreset);
      while (n_acc < NOPS && cyc < 20000) begin
        @(posedge clk); #1;
        cyc++;
        if (n_acc != last) begin
          last = n_acc;
          rif.in_valid = 1'b0;
        end
        rif.out_ready = ($urandom_range(3) != 0);
        if (!rif.in_valid && n_acc < NOPS && $urandom_range(3) != 0) begin
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          if ($urandom_range(7) == 0) a = '1;
          if ($urandom_range(7) == 0) b = {1'b0, {63{1'b0}}} | (64'd1 << (W - 1));
          rif.in_op    = 2'($urandom_range(3));
          rif.in_src1  = a[W-1:0];
          rif.in_src2  = b[W-1:0];
          rif.in_tag   = 5'(n_acc);
          rif.in_valid = 1'b1;
        end
      end
      if (n_acc < NOPS) fail_now("rnd_issue_timeout");
      rif.out_ready = 1'b1;
      for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) fail_now("rnd_drain_timeout");
      check("rnd_count", 64'(n_got), 64'(NOPS));
      n_done++;
    end
  end
endmodule
